// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit and the surrounding pipeline.
// Holds the md_op encoding, default busy durations, FSM state type and the
// SPECIAL-opcode function codes that the decoder maps onto md_op.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MdNone  = 3'd0,
        MdMult  = 3'd1,
        MdMultu = 3'd2,
        MdDiv   = 3'd3,
        MdDivu  = 3'd4,
        MdMthi  = 3'd5,
        MdMtlo  = 3'd6,
        MdRsvd  = 3'd7
    } md_op_e;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } md_state_e;

    localparam int unsigned MultCyclesDefault = 5;
    localparam int unsigned DivCyclesDefault  = 10;

    // SPECIAL opcode and the function codes of the HI/LO instruction group.
    localparam logic [5:0] OpSpecial = 6'h00;
    localparam logic [5:0] FuncMfhi  = 6'h10;
    localparam logic [5:0] FuncMthi  = 6'h11;
    localparam logic [5:0] FuncMflo  = 6'h12;
    localparam logic [5:0] FuncMtlo  = 6'h13;
    localparam logic [5:0] FuncMult  = 6'h18;
    localparam logic [5:0] FuncMultu = 6'h19;
    localparam logic [5:0] FuncDiv   = 6'h1a;
    localparam logic [5:0] FuncDivu  = 6'h1b;

    // True for the four operations that occupy the unit for several cycles.
    function automatic logic is_mul_div(input logic [2:0] op);
        return (op == MdMult) || (op == MdMultu) || (op == MdDiv) || (op == MdDivu);
    endfunction

    function automatic int unsigned max_u(input int unsigned x, input int unsigned y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/mult_div_unit_md_compute.sv
// md_compute: purely combinational arithmetic for the multiply/divide unit.
//   A, B        : operands (rs, rt)
//   md_op       : operation select (mult_div_unit_pkg::md_op_e encoding)
//   result      : {HI, LO} for the selected operation; zero for non-arith ops
//   div_by_zero : div/divu selected with B == 0 (result must not be committed)
module md_compute
    import mult_div_unit_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  md_op,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic        b_zero;
    logic        div_ovf;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;

    assign b_zero  = (B == 32'd0);
    // 0x80000000 / -1 overflows; pin the result instead of relying on tool behaviour.
    assign div_ovf = (A == 32'h8000_0000) && (B == 32'hffff_ffff);

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    always_comb begin
        quot_s = 32'd0;
        rem_s  = 32'd0;
        quot_u = 32'd0;
        rem_u  = 32'd0;
        if (div_ovf) begin
            quot_s = 32'h8000_0000;
        end else if (!b_zero) begin
            quot_s = $signed(A) / $signed(B);
            rem_s  = $signed(A) % $signed(B);
        end
        if (!b_zero) begin
            quot_u = A / B;
            rem_u  = A % B;
        end
    end

    always_comb begin
        result      = 64'd0;
        div_by_zero = 1'b0;
        case (md_op)
            MdMult:  result = prod_s;
            MdMultu: result = prod_u;
            MdDiv: begin
                result      = {rem_s, quot_s};
                div_by_zero = b_zero;
            end
            MdDivu: begin
                result      = {rem_u, quot_u};
                div_by_zero = b_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with architectural HI/LO.
// The result is computed in the issue cycle, held in shadow registers and only
// committed to HI/LO when the fixed busy period expires.
//   clk, reset       : clock, asynchronous active-high reset
//   start, md_op     : E-stage issue strobe and operation
//   A, B             : E-stage operands
//   md_use_D         : D-stage instruction touches the unit
//   busy             : multi-cycle operation in progress
//   md_stall         : stall request to the hazard logic (combinational)
//   HI, LO           : architectural HI/LO registers
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MultCyclesDefault,
    parameter int unsigned DIV_CYCLES  = DivCyclesDefault
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_use_D,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned CntW = $clog2(max_u(MULT_CYCLES, DIV_CYCLES) + 1);

    md_state_e       state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic [31:0]     sh_hi_q, sh_hi_d;
    logic [31:0]     sh_lo_q, sh_lo_d;
    logic            sh_wr_q, sh_wr_d;

    logic [63:0] result;
    logic        div_by_zero;
    logic        start_mul_div;
    logic        is_mult;

    md_compute u_md_compute (
        .A           (A),
        .B           (B),
        .md_op       (md_op),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    assign start_mul_div = start & is_mul_div(md_op);
    assign is_mult       = (md_op == MdMult) || (md_op == MdMultu);

    assign busy     = (state_q == StBusy);
    // Uses the raw issue strobe so the D-stage op stalls even in the issue cycle.
    assign md_stall = (busy | start_mul_div) & md_use_D;
    assign HI       = hi_q;
    assign LO       = lo_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sh_hi_d = sh_hi_q;
        sh_lo_d = sh_lo_q;
        sh_wr_d = sh_wr_q;
        case (state_q)
            StIdle: begin
                if (start_mul_div) begin
                    sh_hi_d = result[63:32];
                    sh_lo_d = result[31:0];
                    // A zero divisor still occupies the unit but leaves HI/LO alone.
                    sh_wr_d = ~div_by_zero;
                    count_d = is_mult ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
                    state_d = StBusy;
                end else if (start && (md_op == MdMthi)) begin
                    hi_d = A;
                end else if (start && (md_op == MdMtlo)) begin
                    lo_d = A;
                end
            end
            StBusy: begin
                // Starts are ignored here, including on the commit edge.
                count_d = count_q - CntW'(1);
                if (count_q <= CntW'(1)) begin
                    count_d = '0;
                    state_d = StIdle;
                    if (sh_wr_q) begin
                        hi_d = sh_hi_q;
                        lo_d = sh_lo_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            sh_hi_q <= 32'd0;
            sh_lo_q <= 32'd0;
            sh_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sh_hi_q <= sh_hi_d;
            sh_lo_q <= sh_lo_d;
            sh_wr_q <= sh_wr_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus randomized
// traffic against an arithmetic reference model of HI/LO and the busy window.
module tb_mult_div_unit;

    localparam int unsigned MultCycles = 5;
    localparam int unsigned DivCycles  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use_d;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural HI/LO, cycles left busy, pending result.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        p_wr;
    int          m_left;

    always #5 clk = ~clk;

    mult_div_unit #(
        .MULT_CYCLES (MultCycles),
        .DIV_CYCLES  (DivCycles)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .A        (a),
        .B        (b),
        .md_use_D (md_use_d),
        .busy     (busy),
        .md_stall (md_stall),
        .HI       (hi),
        .LO       (lo)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // HI/LO outcome of an arithmetic op, from plain 64-bit arithmetic.
    task automatic model_result(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] rh, output logic [31:0] rl,
                                output logic wr);
        longint          sx, sy, sp, sq, sr;
        longint unsigned up;
        logic [63:0]     v;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        rh = 32'd0;
        rl = 32'd0;
        wr = 1'b1;
        case (op)
            3'd1: begin
                sp = sx * sy;
                v  = sp;
                rh = v[63:32];
                rl = v[31:0];
            end
            3'd2: begin
                up = longint'({32'd0, x}) * longint'({32'd0, y});
                v  = up;
                rh = v[63:32];
                rl = v[31:0];
            end
            3'd3: begin
                if (y == 32'd0) begin
                    wr = 1'b0;
                end else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    rl = sq[31:0];
                    rh = sr[31:0];
                end
            end
            default: begin
                if (y == 32'd0) begin
                    wr = 1'b0;
                end else begin
                    rl = x / y;
                    rh = x % y;
                end
            end
        endcase
    endtask

    // One clock of stimulus: drive after negedge, check stall, then check state after the edge.
    task automatic cycle(input logic st, input logic [2:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic use_d);
        logic exp_stall;
        @(negedge clk);
        start    = st;
        md_op    = op;
        a        = x;
        b        = y;
        md_use_d = use_d;
        #1;
        exp_stall = ((m_left > 0) || (st && op >= 3'd1 && op <= 3'd4)) && use_d;
        check_eq("md_stall", md_stall, exp_stall);
        @(posedge clk);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_wr) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (st) begin
            if (op >= 3'd1 && op <= 3'd4) begin
                model_result(op, x, y, p_hi, p_lo, p_wr);
                m_left = (op <= 3'd2) ? MultCycles : DivCycles;
            end else if (op == 3'd5) begin
                m_hi = x;
            end else if (op == 3'd6) begin
                m_lo = x;
            end
        end
        #1;
        check_eq("busy", busy, m_left > 0);
        check_eq("HI", hi, m_hi);
        check_eq("LO", lo, m_lo);
    endtask

    // Issue an op and count the cycles busy stays high, with a bound.
    task automatic issue_count(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                               input logic use_d, output int n);
        n = 0;
        cycle(1'b1, op, x, y, use_d);
        if (busy) n++;
        for (int i = 0; i < 40 && busy; i++) begin
            cycle(1'b0, 3'd0, 32'd0, 32'd0, use_d);
            if (busy) n++;
        end
    endtask

    initial begin
        int n;
        logic [2:0]  rop;
        logic [31:0] rx, ry;

        reset    = 1'b1;
        start    = 1'b0;
        md_op    = 3'd0;
        a        = 32'd0;
        b        = 32'd0;
        md_use_d = 1'b0;
        m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; p_wr = 0; m_left = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_HI", hi, 32'd0);
        check_eq("rst_LO", lo, 32'd0);
        md_use_d = 1'b1;
        #1;
        check_eq("rst_stall_idle", md_stall, 1'b0);
        start = 1'b1;
        md_op = 3'd1;
        #1;
        check_eq("rst_stall_start", md_stall, 1'b1);
        @(negedge clk);
        start = 1'b0;
        md_use_d = 1'b0;
        reset = 1'b0;

        // Signed and unsigned multiply.
        issue_count(3'd1, 32'hffff_ffff, 32'd2, 1'b0, n);
        check_eq("mult_busy_len", n, 5);
        check_eq("mult_HI", hi, 32'hffff_ffff);
        check_eq("mult_LO", lo, 32'hffff_fffe);
        issue_count(3'd2, 32'hffff_ffff, 32'd2, 1'b0, n);
        check_eq("multu_HI", hi, 32'h0000_0001);
        check_eq("multu_LO", lo, 32'hffff_fffe);

        // Signed and unsigned divide.
        issue_count(3'd3, 32'hffff_fff9, 32'd2, 1'b0, n);
        check_eq("div_busy_len", n, 10);
        check_eq("div_LO", lo, 32'hffff_fffd);
        check_eq("div_HI", hi, 32'hffff_ffff);
        issue_count(3'd4, 32'd7, 32'd2, 1'b0, n);
        check_eq("divu_LO", lo, 32'd3);
        check_eq("divu_HI", hi, 32'd1);

        // Divide by zero keeps the full busy period and leaves HI/LO alone.
        issue_count(3'd4, 32'd99, 32'd0, 1'b0, n);
        check_eq("div0_busy_len", n, 10);
        check_eq("div0_HI", hi, 32'd1);
        check_eq("div0_LO", lo, 32'd3);
        cycle(1'b1, 3'd5, 32'h1234_5678, 32'd0, 1'b0);
        check_eq("mthi_HI", hi, 32'h1234_5678);
        check_eq("mthi_busy", busy, 1'b0);
        cycle(1'b1, 3'd6, 32'h0bad_cafe, 32'd0, 1'b0);
        check_eq("mtlo_LO", lo, 32'h0bad_cafe);

        // Stall during busy; starts while busy and on the commit edge are ignored.
        cycle(1'b1, 3'd2, 32'd3, 32'd4, 1'b1);
        for (int i = 0; i < 40 && busy; i++) begin
            cycle(1'b1, (i % 2 == 0) ? 3'd6 : 3'd3, 32'hdead_beef, 32'd5, 1'b1);
        end
        check_eq("ignored_HI", hi, 32'd0);
        check_eq("ignored_LO", lo, 32'd12);
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        check_eq("stall_fall", md_stall, 1'b0);

        // Reset in the third busy cycle of a mult discards the pending result.
        cycle(1'b1, 3'd1, 32'd1000, 32'd1000, 1'b0);
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_HI", hi, 32'd0);
        check_eq("midrst_LO", lo, 32'd0);
        m_hi = 0; m_lo = 0; p_wr = 0; m_left = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        check_eq("midrst_no_commit", lo, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rop = 3'($urandom_range(0, 7));
            rx  = $urandom;
            ry  = $urandom;
            if ($urandom_range(0, 7) == 0) ry = 32'd0;
            if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(1, 9));
            if ($urandom_range(0, 3) == 0) rx = 32'($urandom_range(0, 20)) - 32'd10;
            if (rx == 32'h8000_0000 && ry == 32'hffff_ffff) ry = 32'd3;
            cycle($urandom_range(0, 2) == 0, rop, rx, ry, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 12; i++) cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
